mem_stage_pipe: RTL



---
 rtl/mem_stage_pipe.sv | 86 ++++++++
 1 files changed

// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: registered memory stage with req/ack data memory handshake, store-data bypass and access timeout
module mem_stage_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12,
    parameter logic [4:0] OPC_LW = 5'b01000,
    parameter logic [4:0] OPC_SW = 5'b00111,
    parameter int MAX_WAIT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [31:0]       insn_in,
    input  logic [DATA_W-1:0] o_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              wm_bypass,
    input  logic [DATA_W-1:0] data_writeReg,
    output logic              stall_out,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              valid_out,
    output logic [31:0]       insn_out,
    output logic [DATA_W-1:0] o_out,
    output logic [DATA_W-1:0] d_out,
    output logic              timeout_err
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state;
    logic [7:0] cnt;
    logic [31:0] insn_q;
    logic [DATA_W-1:0] o_q;
    logic [4:0] opcode;
    logic is_mem;
    logic done;
    assign opcode = insn_in[31:27];
    assign is_mem = (opcode == OPC_LW) || (opcode == OPC_SW);
    assign done = dmem_ack || (cnt == 8'(MAX_WAIT - 1));
    assign stall_out = (state == BUSY);
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            insn_q      <= '0;
            o_q         <= '0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            valid_out   <= 1'b0;
            insn_out    <= '0;
            o_out       <= '0;
            d_out       <= '0;
            timeout_err <= 1'b0;
        end else if (state == IDLE) begin
            valid_out <= valid_in && !is_mem;
            if (valid_in && is_mem) begin
                insn_q     <= insn_in;
                o_q        <= o_in;
                dmem_addr  <= o_in[ADDR_W-1:0];
                dmem_wdata <= wm_bypass ? data_writeReg : b_in;
                dmem_req   <= 1'b1;
                dmem_we    <= (opcode == OPC_SW);
                cnt        <= '0;
                state      <= BUSY;
            end else if (valid_in) begin
                insn_out <= insn_in;
                o_out    <= o_in;
                d_out    <= '0;
            end
        end else if (done) begin
            // a timed-out load completes like an ack but returns zero
            state       <= IDLE;
            dmem_req    <= 1'b0;
            valid_out   <= 1'b1;
            insn_out    <= insn_q;
            o_out       <= o_q;
            d_out       <= (dmem_ack && !dmem_we) ? dmem_rdata : '0;
            timeout_err <= timeout_err || !dmem_ack;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end
endmodule
